// File: rtl/fp16_add_arbiter.sv
// Round-robin share of one combinational fp16 adder among NUM_REQ accumulator lanes; grant to rsp_valid is 2 cycles.
// One op in flight: req_ready is held low until the tagged result is taken, and the result stalls indefinitely on rsp_ready=0.
module fp16_add_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [16*NUM_REQ-1:0] req_a,
   input  logic [16*NUM_REQ-1:0] req_b,
   output logic [15:0]           add_a,
   output logic [15:0]           add_b,
   input  logic [15:0]           add_sum,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [15:0]           rsp_sum,
   output logic [ID_W-1:0]       rsp_id,
   output logic [15:0]           op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] grant_id;
   logic            grant_vld;
   logic [ID_W:0]   scan_idx;
   logic            accept;
   logic            rsp_done;
   logic [15:0]     opa [NUM_REQ];
   logic [15:0]     opb [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign opa[i] = req_a[16*i +: 16];
      assign opb[i] = req_b[16*i +: 16];
   end

   // Scan offsets from far to near so the closest valid requester after rr_ptr is the one left standing.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      scan_idx  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
            scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
         end
         if (req_valid[scan_idx[ID_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_id  = scan_idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      accept    = 1'b0;
      rsp_done  = 1'b0;
      case (state)
         IDLE: begin
            if (grant_vld) begin
               req_ready[grant_id] = 1'b1;
               accept              = 1'b1;
               state_nxt           = CALC;
            end
         end
         CALC: state_nxt = RESP;
         RESP: begin
            if (rsp_valid && rsp_ready) begin
               rsp_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         add_a     <= '0;
         add_b     <= '0;
         rsp_valid <= 1'b0;
         rsp_sum   <= '0;
         rsp_id    <= '0;
         op_count  <= '0;
         rr_ptr    <= '0;
      end else begin
         if (accept) begin
            add_a  <= opa[grant_id];
            add_b  <= opb[grant_id];
            rsp_id <= grant_id;
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
         end
         // The adder has had the whole CALC cycle to settle on the registered operands.
         if (state == CALC) begin
            rsp_sum   <= add_sum;
            rsp_valid <= 1'b1;
         end
         if (rsp_done) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_fp16_add_arbiter.sv
// Bench for fp16_add_arbiter: behavioural fp16 adder on add_a/add_b, round-robin reference model, scenario tasks.
module tb_fp16_add_arbiter;
   localparam int N  = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [16*N-1:0] req_a;
   logic [16*N-1:0] req_b;
   logic [15:0]     add_a;
   logic [15:0]     add_b;
   logic [15:0]     add_sum;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [15:0]     rsp_sum;
   logic [IW-1:0]   rsp_id;
   logic [15:0]     op_count;

   logic [15:0]     op_a [N];
   logic [15:0]     op_b [N];

   int n_checks = 0;
   int n_fails  = 0;
   int m_ptr    = 0;
   int m_count  = 0;

   fp16_add_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_sum   (add_sum),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_a[16*i +: 16] = op_a[i];
         req_b[16*i +: 16] = op_b[i];
      end
   end

   function automatic real pow2(int n);
      real r;
      r = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
      else for (int i = 0; i < -n; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real h2r(logic [15:0] h);
      real m;
      if (h[14:10] == 5'd0) m = real'(h[9:0]) * pow2(-24);
      else m = real'({1'b1, h[9:0]}) * pow2(int'(h[14:10]) - 25);
      return h[15] ? -m : m;
   endfunction

   // Truncating encode; overflow saturates to infinity, exact cancellation gives +0.
   function automatic logic [15:0] r2h(real v);
      logic s;
      real  m;
      real  mag;
      int   e;
      int   f;
      if (v == 0.0) return 16'h0000;
      s   = (v < 0.0);
      mag = s ? -v : v;
      m   = mag;
      e   = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0) begin m = m * 2.0; e--; end
      if (e + 15 >= 31) return {s, 5'h1F, 10'h000};
      if (e + 15 <= 0) begin
         f = $rtoi(mag * pow2(24));
         return {s, 5'd0, f[9:0]};
      end
      f = $rtoi((m - 1.0) * 1024.0);
      return {s, 5'(e + 15), f[9:0]};
   endfunction

   function automatic logic [15:0] fp16_add(logic [15:0] a, logic [15:0] b);
      return r2h(h2r(a) + h2r(b));
   endfunction

   always_comb add_sum = fp16_add(add_a, add_b);

   function automatic int rr_pick(logic [N-1:0] v, int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[IW'((ptr + k) % N)]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [15:0] rand_op();
      logic [4:0] e;
      e = 5'($urandom_range(20, 10));
      return {1'($urandom_range(1, 0)), e, 10'($urandom)};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset   = 1'b0;
      m_ptr   = 0;
      m_count = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b, expected 0000 0", req_ready, rsp_valid);
      end
      n_checks++;
      if (add_a !== 16'h0000 || add_b !== 16'h0000) begin
         n_fails++;
         $display("FAIL reset_operands: add_a=%h add_b=%h, expected 0000 0000", add_a, add_b);
      end
      n_checks++;
      if (rsp_sum !== 16'h0000 || rsp_id !== 2'd0 || op_count !== 16'h0000) begin
         n_fails++;
         $display("FAIL reset_rsp: rsp_sum=%h rsp_id=%0d op_count=%h, expected 0000 0 0000", rsp_sum, rsp_id, op_count);
      end
   endtask

   task automatic test_single_op();
      op_a[0] = 16'h3C00;
      op_b[0] = 16'h4000;
      req_valid = 4'b0001;
      rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fails++;
         $display("FAIL single_grant: req_ready=%b expected 0001", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      n_checks++;
      if (rsp_valid !== 1'b0 || add_a !== 16'h3C00 || add_b !== 16'h4000) begin
         n_fails++;
         $display("FAIL single_calc: rsp_valid=%b add_a=%h add_b=%h, expected 0 3c00 4000", rsp_valid, add_a, add_b);
      end
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 16'h4200 || rsp_id !== 2'd0) begin
         n_fails++;
         $display("FAIL single_rsp: rsp_valid=%b rsp_sum=%h rsp_id=%0d, expected 1 4200 0", rsp_valid, rsp_sum, rsp_id);
      end
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || op_count !== 16'd1) begin
         n_fails++;
         $display("FAIL single_count: rsp_valid=%b op_count=%0d, expected 0 1", rsp_valid, op_count);
      end
      m_ptr   = 1;
      m_count = 1;
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < N; i++) begin
         op_a[i] = rand_op();
         op_b[i] = rand_op();
      end
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int g = 0; g < 5; g++) begin
         int          exp_id;
         logic [15:0] ea;
         logic [15:0] eb;
         exp_id = rr_pick(req_valid, m_ptr);
         ea     = op_a[exp_id];
         eb     = op_b[exp_id];
         #1;
         n_checks++;
         if (req_ready !== 4'(1 << exp_id)) begin
            n_fails++;
            $display("FAIL rr_grant: grant %0d req_ready=%b expected %b", g, req_ready, 4'(1 << exp_id));
         end
         @(negedge clk);
         op_a[exp_id] = rand_op();
         op_b[exp_id] = rand_op();
         n_checks++;
         if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL rr_calc: req_ready=%b rsp_valid=%b, expected 0000 0", req_ready, rsp_valid);
         end
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== IW'(exp_id) || rsp_sum !== fp16_add(ea, eb) || req_ready !== 4'b0000) begin
            n_fails++;
            $display("FAIL rr_resp: valid=%b id=%0d sum=%h ready=%b, expected 1 %0d %h 0000",
                     rsp_valid, rsp_id, rsp_sum, req_ready, exp_id, fp16_add(ea, eb));
         end
         @(negedge clk);
         m_ptr = (exp_id + 1) % N;
         m_count++;
      end
      req_valid = '0;
      n_checks++;
      if (op_count !== 16'(m_count)) begin
         n_fails++;
         $display("FAIL rr_count: op_count=%0d expected %0d", op_count, m_count);
      end
   endtask

   task automatic test_cancel();
      logic [15:0] ea;
      logic [15:0] eb;
      op_a[2]   = 16'h3C00;
      op_b[2]   = 16'hBC00;
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 4'b0100) begin
         n_fails++;
         $display("FAIL cancel_grant: req_ready=%b expected 0100", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 16'h0000 || rsp_id !== 2'd2) begin
         n_fails++;
         $display("FAIL cancel_sum: valid=%b sum=%h id=%0d, expected 1 0000 2", rsp_valid, rsp_sum, rsp_id);
      end
      @(negedge clk);
      m_count++;
      op_a[1]   = rand_op();
      op_b[1]   = rand_op();
      ea        = op_a[1];
      eb        = op_b[1];
      req_valid = 4'b0010;
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fails++;
         $display("FAIL wrap_grant: req_ready=%b expected 0010", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== fp16_add(ea, eb)) begin
         n_fails++;
         $display("FAIL wrap_rsp: valid=%b id=%0d sum=%h, expected 1 1 %h", rsp_valid, rsp_id, rsp_sum, fp16_add(ea, eb));
      end
      @(negedge clk);
      m_ptr = 2;
      m_count++;
   endtask

   task automatic test_backpressure();
      logic [N-1:0] mask;
      logic [15:0]  es;
      int           exp_id;
      for (int i = 0; i < N; i++) begin
         op_a[i] = rand_op();
         op_b[i] = rand_op();
      end
      mask      = 4'($urandom_range(15, 1));
      exp_id    = rr_pick(mask, m_ptr);
      es        = fp16_add(op_a[exp_id], op_b[exp_id]);
      req_valid = mask;
      rsp_ready = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 4'(1 << exp_id)) begin
         n_fails++;
         $display("FAIL bp_grant: req_ready=%b expected %b", req_ready, 4'(1 << exp_id));
      end
      @(negedge clk);
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_sum !== es || rsp_id !== IW'(exp_id) || req_ready !== 4'b0000 || op_count !== 16'(m_count)) begin
            n_fails++;
            $display("FAIL bp_hold: cycle %0d valid=%b sum=%h id=%0d ready=%b count=%0d, expected 1 %h %0d 0000 %0d",
                     t, rsp_valid, rsp_sum, rsp_id, req_ready, op_count, es, exp_id, m_count);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = '0;
      m_count++;
      m_ptr = (exp_id + 1) % N;
      n_checks++;
      if (rsp_valid !== 1'b0 || op_count !== 16'(m_count)) begin
         n_fails++;
         $display("FAIL bp_release: valid=%b count=%0d, expected 0 %0d", rsp_valid, op_count, m_count);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] es;
      op_a[3]   = rand_op();
      op_b[3]   = rand_op();
      req_valid = 4'b1000;
      rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 4'b1000) begin
         n_fails++;
         $display("FAIL mid_grant: req_ready=%b expected 1000", req_ready);
      end
      @(negedge clk);
      reset     = 1'b1;
      req_valid = 4'b1111;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || op_count !== 16'd0) begin
         n_fails++;
         $display("FAIL mid_reset: valid=%b count=%0d, expected 0 0", rsp_valid, op_count);
      end
      reset   = 1'b0;
      m_ptr   = 0;
      m_count = 0;
      es      = fp16_add(op_a[0], op_b[0]);
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fails++;
         $display("FAIL mid_regrant: req_ready=%b expected 0001", req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== es) begin
         n_fails++;
         $display("FAIL mid_rsp: valid=%b id=%0d sum=%h, expected 1 0 %h", rsp_valid, rsp_id, rsp_sum, es);
      end
      @(negedge clk);
      m_ptr   = 1;
      m_count = 1;
   endtask

   task automatic test_random();
      logic [N-1:0] mask;
      logic [15:0]  es;
      int           exp_id;
      int           wait_c;
      mask = 4'($urandom_range(15, 1));
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(3, 0) == 0) begin
            req_valid = '0;
            #1;
            n_checks++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
               n_fails++;
               $display("FAIL rand_idle: ready=%b valid=%b, expected 0000 0", req_ready, rsp_valid);
            end
            @(negedge clk);
         end
         req_valid = mask;
         rsp_ready = 1'($urandom_range(1, 0));
         exp_id    = rr_pick(mask, m_ptr);
         es        = fp16_add(op_a[exp_id], op_b[exp_id]);
         #1;
         n_checks++;
         if (req_ready !== 4'(1 << exp_id) || op_count !== 16'(m_count)) begin
            n_fails++;
            $display("FAIL rand_grant: op %0d ready=%b count=%0d, expected %b %0d", n, req_ready, op_count, 4'(1 << exp_id), m_count);
         end
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            op_a[i] = rand_op();
            op_b[i] = rand_op();
         end
         mask      = 4'($urandom_range(15, 1));
         req_valid = 4'($urandom_range(15, 0));
         wait_c    = $urandom_range(3, 0);
         rsp_ready = 1'($urandom_range(1, 0));
         n_checks++;
         if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL rand_calc: ready=%b valid=%b, expected 0000 0", req_ready, rsp_valid);
         end
         for (int t = 0; t <= wait_c; t++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== IW'(exp_id) || rsp_sum !== es || req_ready !== 4'b0000 || op_count !== 16'(m_count)) begin
               n_fails++;
               $display("FAIL rand_resp: op %0d valid=%b id=%0d sum=%h ready=%b count=%0d, expected 1 %0d %h 0000 %0d",
                        n, rsp_valid, rsp_id, rsp_sum, req_ready, op_count, exp_id, es, m_count);
            end
            rsp_ready = (t == wait_c);
         end
         @(negedge clk);
         m_ptr = (exp_id + 1) % N;
         m_count++;
      end
      req_valid = '0;
   endtask

   task automatic test_wrap();
      req_valid = '0;
      rsp_ready = 1'b1;
      force dut.op_count = 16'hFFFE;
      @(negedge clk);
      release dut.op_count;
      m_count = 32'hFFFE;
      for (int g = 0; g < 2; g++) begin
         op_a[m_ptr] = rand_op();
         op_b[m_ptr] = rand_op();
         req_valid   = 4'(1 << m_ptr);
         @(negedge clk);
         req_valid = '0;
         @(negedge clk);
         n_checks++;
         if (op_count !== 16'(m_count)) begin
            n_fails++;
            $display("FAIL wrap_hold: op_count=%h expected %h", op_count, 16'(m_count));
         end
         @(negedge clk);
         m_ptr = (m_ptr + 1) % N;
         m_count++;
         n_checks++;
         if (op_count !== 16'(m_count)) begin
            n_fails++;
            $display("FAIL wrap_count: op_count=%h expected %h", op_count, 16'(m_count));
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end
      test_reset();
      test_single_op();
      test_round_robin();
      test_cancel();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fails);
      $fatal(1, "watchdog expired");
   end

endmodule
